// File: rtl/pipe_ctrl.sv
// Pipeline control: priority stall vector, branch flush and held PC redirect.
// Define PIPE_CTRL_PERF_EN to add the cycle/stall/flush performance counters.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             stallreq_if_in,
    input  logic             stallreq_id_in,
    input  logic             stallreq_ex_in,
    input  logic             stallreq_mem_in,
    input  logic             branch_taken_ex_in,
    input  logic [31:0]      branch_target_ex_in,
    output logic [5:0]       stall_out,
    output logic             flush_out,
    output logic             pc_redirect_out,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]      pc_target_out,
    output logic [CNT_W-1:0] cycle_cnt_out,
    output logic [CNT_W-1:0] stall_cnt_out,
    output logic [CNT_W-1:0] flush_cnt_out
`else
    output logic [31:0]      pc_target_out
`endif
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] tgt_q, tgt_d;

    logic [5:0]  stall_hi;
    logic        capture;
    logic        pending;
    logic        accept;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        stall_hi        = 6'b000000;
        stall_out       = 6'b000000;
        capture         = 1'b0;
        pending         = 1'b0;
        flush_out       = 1'b0;
        pc_redirect_out = 1'b0;
        pc_target_out   = 32'h0;
        accept          = 1'b0;
        state_d         = state_q;
        tgt_d           = tgt_q;

        // Upper stall bits never depend on the ID request, so capture (which needs bit 3)
        // can be decided first and then used to mask the wrong-path ID hazard.
        if (!rst_in) begin
            if (!rdy_in)              stall_hi = 6'b111111;
            else if (stallreq_mem_in) stall_hi = 6'b011111;
            else if (stallreq_ex_in)  stall_hi = 6'b001111;
        end

        capture   = !rst_in && (state_q == IDLE) && branch_taken_ex_in
                    && !stall_hi[3] && rdy_in;
        pending   = !rst_in && (state_q == PENDING);
        flush_out = capture || pending;

        stall_out = stall_hi;
        if (!rst_in && (stall_hi == 6'b000000)) begin
            if (stallreq_id_in && !flush_out) stall_out = 6'b000111;
            else if (stallreq_if_in)          stall_out = 6'b000011;
        end

        pc_redirect_out = flush_out;
        if (pending)      pc_target_out = tgt_q;
        else if (capture) pc_target_out = branch_target_ex_in;

        accept = flush_out && !stall_out[0];

        if (capture && stall_out[0]) begin
            state_d = PENDING;
            tgt_d   = branch_target_ex_in;
        end else if (pending && accept) begin
            state_d = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            tgt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (rdy_in && !rst_in) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
            if (stall_out != 6'b000000) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (accept)                 flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign cycle_cnt_out = cycle_cnt_q;
    assign stall_cnt_out = stall_cnt_q;
    assign flush_cnt_out = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; inputs change on the falling edge,
// outputs are compared 1 ns later, state advances on the rising edge.
module tb_pipe_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        stallreq_if_in, stallreq_id_in, stallreq_ex_in, stallreq_mem_in;
    logic        branch_taken_ex_in;
    logic [31:0] branch_target_ex_in;
    logic [5:0]  stall_out;
    logic        flush_out, pc_redirect_out;
    logic [31:0] pc_target_out;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] cycle_cnt_out, stall_cnt_out, flush_cnt_out;
`endif

    int vectors = 0;
    int miscompares = 0;

    pipe_ctrl #(.CNT_W(32)) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .rdy_in              (rdy_in),
        .stallreq_if_in      (stallreq_if_in),
        .stallreq_id_in      (stallreq_id_in),
        .stallreq_ex_in      (stallreq_ex_in),
        .stallreq_mem_in     (stallreq_mem_in),
        .branch_taken_ex_in  (branch_taken_ex_in),
        .branch_target_ex_in (branch_target_ex_in),
        .stall_out           (stall_out),
        .flush_out           (flush_out),
        .pc_redirect_out     (pc_redirect_out),
`ifdef PIPE_CTRL_PERF_EN
        .pc_target_out       (pc_target_out),
        .cycle_cnt_out       (cycle_cnt_out),
        .stall_cnt_out       (stall_cnt_out),
        .flush_cnt_out       (flush_cnt_out)
`else
        .pc_target_out       (pc_target_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Next cycle: wait for the falling edge, apply inputs, let logic settle.
    task automatic cyc(input logic rst, input logic rdy, input logic rif, input logic rid,
                       input logic rex, input logic rmem, input logic br, input logic [31:0] tgt);
        @(negedge clk_in);
        rst_in = rst; rdy_in = rdy;
        stallreq_if_in = rif; stallreq_id_in = rid;
        stallreq_ex_in = rex; stallreq_mem_in = rmem;
        branch_taken_ex_in = br; branch_target_ex_in = tgt;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [5:0] st, input logic fl,
                              input logic rd, input logic [31:0] tg);
        check({tag, ".stall"},    {26'h0, stall_out},      {26'h0, st});
        check({tag, ".flush"},    {31'h0, flush_out},      {31'h0, fl});
        check({tag, ".redirect"}, {31'h0, pc_redirect_out}, {31'h0, rd});
        check({tag, ".target"},   pc_target_out,           tg);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1;
        stallreq_if_in = 1'b0; stallreq_id_in = 1'b0;
        stallreq_ex_in = 1'b0; stallreq_mem_in = 1'b0;
        branch_taken_ex_in = 1'b0; branch_target_ex_in = 32'h0;

        // Reset dominates everything, including rdy=0 and a branch.
        cyc(1, 0, 1, 1, 1, 1, 1, 32'h0000_1234);
        expect_out("rst", 6'b000000, 0, 0, 32'h0);
        cyc(1, 1, 0, 0, 0, 0, 0, 32'h0);

        // T1 priority chain.
        cyc(0, 1, 0, 1, 0, 1, 0, 32'h0);
        check("t1.mem_id", {26'h0, stall_out}, 32'h1F);
        stallreq_mem_in = 1'b0; #1;
        check("t1.id", {26'h0, stall_out}, 32'h07);
        cyc(0, 1, 1, 0, 1, 0, 0, 32'h0);
        check("t1.ex_if", {26'h0, stall_out}, 32'h0F);
        cyc(0, 1, 1, 0, 0, 0, 0, 32'h0);
        check("t1.if", {26'h0, stall_out}, 32'h03);
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h0);
        expect_out("t1.none", 6'b000000, 0, 0, 32'h0);

        // T2 global not-ready, and branch with rdy=0 is not captured.
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0000_4444);
        expect_out("t2.notrdy", 6'b111111, 0, 0, 32'h0);

        // T3 immediate redirect, then idle.
        cyc(0, 1, 0, 0, 0, 0, 1, 32'h0000_1000);
        expect_out("t3.c5", 6'b000000, 1, 1, 32'h0000_1000);
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h0);
        expect_out("t3.c6", 6'b000000, 0, 0, 32'h0);

        // Capture with a simultaneous ID hazard: the hazard is masked by the flush.
        cyc(0, 1, 0, 1, 0, 0, 1, 32'h0000_0ABC);
        expect_out("idmask", 6'b000000, 1, 1, 32'h0000_0ABC);
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h0);
        expect_out("idmask.after", 6'b000000, 0, 0, 32'h0);

        // T4 held redirect under IF stall, plus rdy=0 freeze and a new branch ignored.
        cyc(0, 1, 1, 0, 0, 0, 1, 32'h0000_1000);
        expect_out("t4.c5", 6'b000011, 1, 1, 32'h0000_1000);
        cyc(0, 1, 1, 1, 0, 0, 0, 32'h0000_DEAD);
        expect_out("t4.c6", 6'b000011, 1, 1, 32'h0000_1000);
        cyc(0, 1, 1, 0, 0, 0, 1, 32'h0000_3000);
        expect_out("t4.c7", 6'b000011, 1, 1, 32'h0000_1000);
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h0);
        expect_out("t2.pend_frz", 6'b111111, 1, 1, 32'h0000_1000);
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h0);
        expect_out("t4.c8", 6'b000000, 1, 1, 32'h0000_1000);
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h0);
        expect_out("t4.c9", 6'b000000, 0, 0, 32'h0);

        // T5 branch under MEM stall is not captured until re-presented.
        cyc(0, 1, 0, 0, 0, 1, 1, 32'h0000_2000);
        expect_out("t5.c3", 6'b011111, 0, 0, 32'h0);
        cyc(0, 1, 0, 0, 0, 0, 1, 32'h0000_2000);
        expect_out("t5.c4", 6'b000000, 1, 1, 32'h0000_2000);
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h0);
        expect_out("t5.c5", 6'b000000, 0, 0, 32'h0);

        // EX stall also blocks capture.
        cyc(0, 1, 0, 0, 1, 0, 1, 32'h0000_5000);
        expect_out("exblk", 6'b001111, 0, 0, 32'h0);

        // T6 reset in the middle of a pending redirect drops it.
        cyc(0, 1, 1, 0, 0, 0, 1, 32'h0000_1000);
        expect_out("t6.c5", 6'b000011, 1, 1, 32'h0000_1000);
        cyc(1, 1, 1, 0, 0, 0, 0, 32'h0);
        expect_out("t6.c6", 6'b000000, 0, 0, 32'h0);
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h0);
        expect_out("t6.c7", 6'b000000, 0, 0, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
        check("t6.cycle_cnt", cycle_cnt_out, 32'd0);
        check("t6.stall_cnt", stall_cnt_out, 32'd0);
        check("t6.flush_cnt", flush_cnt_out, 32'd0);
        // c7 idle, c8 IF stall, c9 redirect accepted, c10 not ready, c11 sample.
        cyc(0, 1, 1, 0, 0, 0, 0, 32'h0);
        cyc(0, 1, 0, 0, 0, 0, 1, 32'h0000_7000);
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h0);
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h0);
        check("perf.cycle_cnt", cycle_cnt_out, 32'd3);
        check("perf.stall_cnt", stall_cnt_out, 32'd1);
        check("perf.flush_cnt", flush_cnt_out, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
